// File: rtl/seg7_scan_display_pkg.sv
// Segment encodings for the multiplexed 7-segment driver.
// Cathodes are active-low; bit 6 is segment a and bit 0 is segment g.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_of_nibble(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = SEG_0;
            4'h1: s = SEG_1;
            4'h2: s = SEG_2;
            4'h3: s = SEG_3;
            4'h4: s = SEG_4;
            4'h5: s = SEG_5;
            4'h6: s = SEG_6;
            4'h7: s = SEG_7;
            4'h8: s = SEG_8;
            4'h9: s = SEG_9;
            4'hA: s = SEG_A;
            4'hB: s = SEG_B;
            4'hC: s = SEG_C;
            4'hD: s = SEG_D;
            4'hE: s = SEG_E;
            default: s = SEG_F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// Value-load bus of the display: data, format controls and the ready handshake.
interface seg7_scan_display_if #(
    parameter int DIGITS = 4,
    parameter int DATA_W = 4 * DIGITS
);
    logic [DATA_W-1:0] value;
    logic              load;
    logic              ready;
    logic              mode;
    logic              blank_lz;
    logic              err;
    logic [DIGITS-1:0] dp_in;
    logic [DIGITS-1:0] blink_en;

    modport master (output value, load, mode, blank_lz, err, dp_in, blink_en, input ready);
    modport slave  (input value, load, mode, blank_lz, err, dp_in, blink_en, output ready);
endinterface

// File: rtl/seg7_scan_display_bin2bcd.sv
// Sequential shift-add-3 binary to BCD converter, one input bit per cycle.
module bin2bcd_seq #(
    parameter int DATA_W = 16,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [DATA_W-1:0]   bin_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                ovf_o,
    output logic [4*DIGITS-1:0] bcd_o
);
    // Enough BCD digits to hold any DATA_W-bit value, so overflow is exact.
    localparam int BCD_D = (DATA_W / 3 + 1 > DIGITS) ? DATA_W / 3 + 1 : DIGITS;
    localparam int ACC_W = 4 * BCD_D;
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t             state_q;
    logic [DATA_W-1:0]  sh_q;
    logic [ACC_W-1:0]   acc_q, acc_d, adj;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q, done_q;

    always_comb begin
        adj = acc_q;
        for (int i = 0; i < BCD_D; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        acc_d = (adj << 1) | {{(ACC_W-1){1'b0}}, sh_q[DATA_W-1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        sh_q    <= bin_i;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    acc_q <= acc_d;
                    sh_q  <= sh_q << 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign bcd_o  = acc_q[4*DIGITS-1:0];

    if (BCD_D > DIGITS) begin : g_ovf
        assign ovf_o = |acc_q[ACC_W-1:4*DIGITS];
    end else begin : g_no_ovf
        assign ovf_o = 1'b0;
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed 7-segment display driver: hex/decimal buffer, scan with ghosting
// guard, leading-zero blanking, per-digit blink and decimal points.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int DATA_W      = 4 * DIGITS,
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 250
) (
    input  logic                clock_100Mhz,
    input  logic                reset,
    seg7_scan_display_if.slave  bus,
    output logic [DIGITS-1:0]   Anode_Activate,
    output logic [6:0]          LED_out,
    output logic                dp_out
);
    localparam int BUF_W = 4 * DIGITS;
    localparam int REF_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic             conv_busy, conv_done, conv_ovf, conv_start, accept;
    logic [BUF_W-1:0] conv_bcd;
    logic [BUF_W-1:0] buf_q;
    logic             ovf_q, lz_q, lz_pend_q;

    logic [REF_W-1:0] ref_q, ref_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic             phase_q, phase_d;

    logic [DIGITS-1:0] anode_q, anode_d;
    logic [6:0]        led_q, led_d, seg;
    logic              dp_q, dp_d;
    logic [3:0]        cur_nib;
    logic              blk_sel, dp_sel, lz_sel, higher_zero, blink_off, guard;

    assign bus.ready  = ~conv_busy;
    assign accept     = bus.load & ~conv_busy;
    assign conv_start = accept & bus.mode;

    bin2bcd_seq #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_bcd (
        .clk     (clock_100Mhz),
        .rst_n   (reset),
        .start_i (conv_start),
        .bin_i   (bus.value),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .ovf_o   (conv_ovf),
        .bcd_o   (conv_bcd)
    );

    // The buffer only ever takes a complete value, so the scan never sees a half-converted number.
    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            buf_q     <= '0;
            ovf_q     <= 1'b0;
            lz_q      <= 1'b0;
            lz_pend_q <= 1'b0;
        end else begin
            if (accept && !bus.mode) begin
                buf_q <= BUF_W'(bus.value);
                ovf_q <= 1'b0;
                lz_q  <= bus.blank_lz;
            end else if (conv_done) begin
                buf_q <= conv_bcd;
                ovf_q <= conv_ovf;
                lz_q  <= lz_pend_q;
            end
            if (conv_start) lz_pend_q <= bus.blank_lz;
        end
    end

    always_comb begin
        ref_d     = ref_q + 1'b1;
        idx_d     = idx_q;
        blk_cnt_d = blk_cnt_q;
        phase_d   = phase_q;
        if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
            ref_d = '0;
            if (idx_q == IDX_W'(DIGITS - 1)) begin
                idx_d = '0;
                if (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
                    blk_cnt_d = '0;
                    phase_d   = ~phase_q;
                end else begin
                    blk_cnt_d = blk_cnt_q + 1'b1;
                end
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_comb begin
        cur_nib     = '0;
        blk_sel     = 1'b0;
        dp_sel      = 1'b0;
        lz_sel      = 1'b0;
        anode_d     = '1;
        higher_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            higher_zero = higher_zero & (buf_q[4*i +: 4] == 4'd0);
            if (idx_q == IDX_W'(i)) begin
                cur_nib    = buf_q[4*i +: 4];
                blk_sel    = bus.blink_en[i];
                dp_sel     = bus.dp_in[i];
                lz_sel     = lz_q & higher_zero & (i != 0);
                anode_d[i] = 1'b0;
            end
        end
        blink_off = ~phase_q & blk_sel;
        if (blink_off)              seg = SEG_BLANK;
        else if (bus.err || ovf_q)  seg = SEG_DASH;
        else if (lz_sel)            seg = SEG_BLANK;
        else                        seg = seg_of_nibble(cur_nib);
        // Slot cycle 0 keeps every digit dark while the cathodes settle.
        guard = (ref_q == '0);
        if (guard) begin
            anode_d = '1;
            led_d   = SEG_BLANK;
            dp_d    = 1'b1;
        end else begin
            led_d   = seg;
            dp_d    = ~(dp_sel & ~blink_off);
        end
    end

    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            ref_q     <= '0;
            idx_q     <= '0;
            blk_cnt_q <= '0;
            phase_q   <= 1'b1;
            anode_q   <= '1;
            led_q     <= SEG_BLANK;
            dp_q      <= 1'b1;
        end else begin
            ref_q     <= ref_d;
            idx_q     <= idx_d;
            blk_cnt_q <= blk_cnt_d;
            phase_q   <= phase_d;
            anode_q   <= anode_d;
            led_q     <= led_d;
            dp_q      <= dp_d;
        end
    end

    assign Anode_Activate = anode_q;
    assign LED_out        = led_q;
    assign dp_out         = dp_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: directed vector table, hand sequences and a
// randomized run against a digit-level reference model.
module tb_seg7_scan_display;

    localparam int D = 4;
    localparam int W = 16;
    localparam int R = 4;
    localparam int B = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic [D-1:0] anode;
    logic [6:0]   led;
    logic         dp;

    seg7_scan_display_if #(.DIGITS(D), .DATA_W(W)) bus ();

    seg7_scan_display #(.DIGITS(D), .DATA_W(W), .REFRESH_DIV(R), .BLINK_DIV(B)) dut (
        .clock_100Mhz   (clk),
        .reset          (rst_n),
        .bus            (bus),
        .Anode_Activate (anode),
        .LED_out        (led),
        .dp_out         (dp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference segment shapes written as lit segments (a..g), inverted for the active-low pins.
    function automatic logic [6:0] seg_exp(input int d);
        logic [6:0] lit;
        case (d)
            0: lit = 7'b1111110;  1: lit = 7'b0110000;  2: lit = 7'b1101101;
            3: lit = 7'b1111001;  4: lit = 7'b0110011;  5: lit = 7'b1011011;
            6: lit = 7'b1011111;  7: lit = 7'b1110000;  8: lit = 7'b1111111;
            9: lit = 7'b1111011;  10: lit = 7'b1110111; 11: lit = 7'b0011111;
            12: lit = 7'b1001110; 13: lit = 7'b0111101; 14: lit = 7'b1001111;
            default: lit = 7'b1000111;
        endcase
        return ~lit;
    endfunction

    // Reference model: edge count since reset release plus the digit buffer.
    int  n;
    int  mdig[D];
    bit  movf, mlz, mready;
    int  conv_end, pend_v;
    bit  pend_lz;

    task automatic model_reset();
        n = 0;
        for (int i = 0; i < D; i++) mdig[i] = 0;
        movf = 0; mlz = 0; mready = 1; conv_end = -1; pend_v = 0; pend_lz = 0;
    endtask

    task automatic set_decimal(input int v);
        int p;
        p = 1;
        for (int i = 0; i < D; i++) begin
            mdig[i] = (v / p) % 10;
            p = p * 10;
        end
        movf = (v >= p);
    endtask

    task automatic step();
        int m, c, slot, idx, sval;
        int sdig[D];
        bit sovf, slz, serr, acc, smode, slzin, on_ph, boff, allz;
        logic [D-1:0] sdp, sblk, ea;
        logic [6:0] el;
        m = n; sdig = mdig; sovf = movf; slz = mlz;
        serr = bus.err; sdp = bus.dp_in; sblk = bus.blink_en;
        acc = bus.load && mready; smode = bus.mode; slzin = bus.blank_lz;
        sval = int'(bus.value);
        @(posedge clk);
        #1;
        n++;
        if (!mready && n == conv_end) begin
            set_decimal(pend_v);
            mlz = pend_lz;
            mready = 1;
        end
        if (acc) begin
            if (!smode) begin
                for (int i = 0; i < D; i++) mdig[i] = (sval >> (4 * i)) & 15;
                movf = 0;
                mlz = slzin;
            end else begin
                pend_v = sval; pend_lz = slzin; conv_end = n + W + 1; mready = 0;
            end
        end
        chk("ready", int'(bus.ready), int'(mready));
        c = m % R; slot = m / R; idx = slot % D;
        on_ph = (((slot / D) / B) % 2) == 0;
        ea = '1;
        if (c != 0) ea[idx] = 1'b0;
        chk("anode", int'(anode), int'(ea));
        if (c != 0) begin
            boff = !on_ph && sblk[idx];
            allz = 1;
            for (int j = idx; j < D; j++) if (sdig[j] != 0) allz = 0;
            if (boff)                          el = 7'h7F;
            else if (serr || sovf)             el = 7'b1111110;
            else if (slz && idx != 0 && allz)  el = 7'h7F;
            else                               el = seg_exp(sdig[idx]);
            chk("led", int'(led), int'(el));
            chk("dp", int'(dp), (sdp[idx] && !boff) ? 0 : 1);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_anode", int'(anode), 'hF);
        chk("rst_led", int'(led), 'h7F);
        chk("rst_dp", int'(dp), 1);
        chk("rst_ready", int'(bus.ready), 1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [6:0] got[D];
    bit         seen[D];

    task automatic collect();
        for (int j = 0; j < D; j++) begin got[j] = '0; seen[j] = 0; end
        for (int k = 0; k < 2 * R * D; k++) begin
            step();
            for (int j = 0; j < D; j++) begin
                if (anode == ~(D'(1) << j)) begin got[j] = led; seen[j] = 1; end
            end
        end
    endtask

    task automatic check_digits(input string tag, input logic [27:0] segs);
        for (int j = 0; j < D; j++)
            chk($sformatf("%s_d%0d", tag, j), seen[j] ? int'(got[j]) : -1, int'(segs[7*j +: 7]));
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!bus.ready && cnt < 40) begin step(); cnt++; end
    endtask

    typedef struct {
        bit          mode;
        bit          lz;
        int          val;
        logic [27:0] segs;
    } vec_t;

    vec_t vt[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt, lit0, blank0, others_blank, dp_mis;
        vt[0] = '{1'b0, 1'b0, 32'h1A3F, {7'b1001111, 7'b0001000, 7'b0000110, 7'b0111000}};
        vt[1] = '{1'b1, 1'b0, 1234,     {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}};
        vt[2] = '{1'b1, 1'b0, 10000,    {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110}};
        vt[3] = '{1'b1, 1'b1, 7,        {7'b1111111, 7'b1111111, 7'b1111111, 7'b0001111}};
        vt[4] = '{1'b1, 1'b1, 0,        {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}};
        vt[5] = '{1'b0, 1'b1, 32'h00B0, {7'b1111111, 7'b1111111, 7'b1100000, 7'b0000001}};
        vt[6] = '{1'b1, 1'b0, 9999,     {7'b0000100, 7'b0000100, 7'b0000100, 7'b0000100}};
        vt[7] = '{1'b0, 1'b0, 32'h0000, {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}};

        rst_n = 1'b1;
        bus.value = '0; bus.load = 0; bus.mode = 0; bus.blank_lz = 0;
        bus.err = 0; bus.dp_in = '0; bus.blink_en = '0;
        #1;
        do_reset();

        // Anode scan pattern from release, through the wrap back to digit 0.
        begin
            logic [3:0] aseq [18] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF,
                                      4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF, 4'hE};
            for (int k = 0; k < 18; k++) begin
                step();
                chk($sformatf("scan_%0d", k), int'(anode), int'(aseq[k]));
            end
        end

        for (int v = 0; v < 8; v++) begin
            wait_ready(cnt);
            bus.mode = vt[v].mode; bus.blank_lz = vt[v].lz;
            bus.value = W'(vt[v].val); bus.load = 1;
            step();
            bus.load = 0;
            wait_ready(cnt);
            chk($sformatf("vec%0d_busy_cycles", v), cnt, vt[v].mode ? W + 1 : 0);
            collect();
            check_digits($sformatf("vec%0d", v), vt[v].segs);
        end

        // A load arriving mid-conversion must be dropped.
        bus.mode = 1; bus.blank_lz = 0; bus.value = 16'd1234; bus.load = 1;
        step();
        bus.load = 0;
        repeat (3) step();
        bus.mode = 0; bus.value = 16'hFFFF; bus.load = 1;
        step();
        bus.load = 0;
        wait_ready(cnt);
        chk("busy_load_ready", int'(bus.ready), 1);
        collect();
        check_digits("busy_load", vt[1].segs);

        // Blink on digit 0 only, with its decimal point requested.
        bus.blink_en = 4'b0001; bus.dp_in = 4'b0001;
        lit0 = 0; blank0 = 0; others_blank = 0; dp_mis = 0;
        for (int k = 0; k < 4 * B * R * D; k++) begin
            step();
            if (anode == 4'b1110) begin
                if (led == 7'h7F) begin blank0++; if (dp != 1'b1) dp_mis++; end
                else begin lit0++; if (dp != 1'b0) dp_mis++; end
            end else if (anode != 4'hF && led == 7'h7F) begin
                others_blank++;
            end
        end
        chk("blink_off_seen", int'(blank0 > 0), 1);
        chk("blink_on_seen", int'(lit0 > 0), 1);
        chk("blink_others_steady", others_blank, 0);
        chk("blink_dp_follows", dp_mis, 0);
        bus.blink_en = '0; bus.dp_in = '0;

        // Reset in the middle of a decimal conversion.
        wait_ready(cnt);
        bus.mode = 1; bus.value = 16'd4321; bus.load = 1;
        step();
        bus.load = 0;
        repeat (5) step();
        do_reset();
        collect();
        check_digits("after_abort", {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001});

        for (int k = 0; k < 1200; k++) begin
            bus.load = ($urandom % 6) == 0;
            bus.mode = $urandom % 2;
            bus.blank_lz = $urandom % 2;
            case ($urandom % 3)
                0: bus.value = W'($urandom_range(0, 30));
                1: bus.value = W'($urandom_range(9980, 10020));
                default: bus.value = W'($urandom);
            endcase
            if ($urandom % 20 == 0) bus.err = ~bus.err;
            if ($urandom % 25 == 0) bus.dp_in = D'($urandom);
            if ($urandom % 40 == 0) bus.blink_en = D'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_display.md
SEG7_SCAN_DISPLAY -- requirements
Module: seg7_scan_display

Interface
REQ-001 Parameter DIGITS, default 4, meaning number of multiplexed digits, legal 1..8.
REQ-002 Parameter DATA_W, default 4*DIGITS, meaning width of the binary input value.
REQ-003 Parameter REFRESH_DIV, default 100000, meaning clock cycles per digit slot; minimum 2.
REQ-004 Parameter BLINK_DIV, default 250, meaning full digit-scan rounds per blink half-period.
REQ-005 Port clock_100Mhz  in  1  system clock; all logic on its rising edge.
REQ-006 Port reset  in  1  asynchronous, active-low reset.
REQ-007 Port value  in  DATA_W  binary number to display.
REQ-008 Port load  in  1  request to capture value; accepted only when ready=1.
REQ-009 Port ready  out  1  high when a new value can be accepted.
REQ-010 Port mode  in  1  0 = hexadecimal, 1 = decimal; sampled with load.
REQ-011 Port blank_lz  in  1  enables leading-zero blanking; sampled with load.
REQ-012 Port err  in  1  level input; while high every digit shows dash.
REQ-013 Port dp_in  in  DIGITS  per-digit decimal point request, bit 0 = rightmost digit.
REQ-014 Port blink_en  in  DIGITS  per-digit blink enable.
REQ-015 Port Anode_Activate  out  DIGITS  active-low digit enables, one-hot-low or all high.
REQ-016 Port LED_out  out  7  active-low cathodes, bit 6 = segment a, bit 0 = segment g.
REQ-017 Port dp_out  out  1  active-low decimal point cathode.

Function
REQ-018 Hex mode: load with ready=1 writes nibble i of value to display buffer digit i on the next edge; ready stays 1.
REQ-019 Hex mode, DATA_W < 4*DIGITS: upper digits zero-filled; DATA_W > 4*DIGITS: excess high bits ignored.
REQ-020 Decimal mode: load starts sequential shift-add-3 conversion, one bit per cycle; ready drops the cycle after load and returns high DATA_W+1 cycles after load, buffer updated on that same edge.
REQ-021 Decimal value >= 10^DIGITS: buffer set to all dashes (overflow), not a truncated number.
REQ-022 Buffer is replaced atomically; the scan never shows a partially converted number.
REQ-023 load while ready=0 is ignored; no queuing.
REQ-024 Refresh counter counts 0..REFRESH_DIV-1 and wraps; on wrap digit index advances 0..DIGITS-1 and wraps to 0.
REQ-025 First cycle of every digit slot: all anodes high (ghosting guard); remaining cycles: only the indexed anode low.
REQ-026 LED_out and dp_out are registered and change on the same edge as Anode_Activate.
REQ-027 Segment codes: 0-9, A, b, C, d, E, F; dash = 1111110; blank = 1111111.
REQ-028 Leading-zero blanking: digit i blank if it and all higher digits are zero, except digit 0 never blanked.
REQ-029 Blink phase toggles every BLINK_DIV digit-index wraps to 0; in off phase digits with blink_en=1 show blank and dp off.
REQ-030 dp_out low when dp_in of the indexed digit is 1 and the digit is not blink-blanked; err does not affect dp.
REQ-031 Priority per digit: blink-off blank > err dash > overflow dash > leading-zero blank > buffer code.
REQ-032 DIGITS=1: index constant 0, guard cycle still applied each slot.

Reset
REQ-033 While reset is low: Anode_Activate all 1, LED_out 1111111, dp_out 1, ready 1, buffer zero, counters zero, blink phase on, converter idle.
REQ-034 Reset asserted mid-conversion aborts it; buffer holds zero after release.
REQ-035 First digit slot after reset release starts at index 0 with a guard cycle.

Structure
REQ-036 Package seg7_pkg holds the segment encoding constants (digits, A-F, dash, blank) and the nibble-to-segment function.
REQ-037 Sub-module bin2bcd_seq (parameters DATA_W, DIGITS; start/busy/done handshake; overflow flag) performs the decimal conversion.

Verification
REQ-038 DIGITS=4, mode=0, value=16'h1A3F, load -> digits 0..3 show F, 3, A, 1 (0111000, 0000110, 0001000, 1001111).
REQ-039 mode=1, value=16'd1234, load -> ready low for 17 cycles, then digits show 4,3,2,1; value=16'd10000 -> all four digits 1111110.
REQ-040 mode=1, blank_lz=1, value=16'd7 -> digit 0 shows 7, digits 1-3 show 1111111; value=0 -> digit 0 shows 0.
REQ-041 REFRESH_DIV=4: anodes follow 1111,1110,1110,1110,1111,1101,... and wrap after digit 3 to 1110.
REQ-042 BLINK_DIV=2, blink_en=4'b0001, dp_in=4'b0001 -> digit 0 segments and dp blank every other 2-round half-period, other digits steady.
REQ-043 reset low at cycle 5 of a decimal conversion -> all outputs at reset values, ready=1, buffer reads 0000 after release.
